// File: rtl/conv_quan_param_loader_pkg.sv
// Shared constants and state encoding for the quantization parameter loader.
// Imported by the loader and its stream interface.
package conv_quan_param_loader_pkg;

  localparam int CHANNEL_OUT_NUM = 8;
  localparam int GROUP_SHIFT     = 3;
  localparam int WIDTH_DATA_ADD  = 32;
  localparam int WIDTH_SHIFT     = 8;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_LD_BIAS  = 5'b00010,
    ST_LD_SCALE = 5'b00100,
    ST_LD_SHIFT = 5'b01000,
    ST_DONE     = 5'b10000
  } state_t;

endpackage

// File: rtl/conv_quan_param_loader_if.sv
// Valid/ready parameter stream feeding the loader.
// The loader is the slave; the DMA front end is the master.
interface conv_quan_param_loader_if #(
  parameter int DATA_W = 256
);

  logic [DATA_W-1:0] S_Data;
  logic              S_Valid;
  logic              S_Ready;

  modport master (
    output S_Data,
    output S_Valid,
    input  S_Ready
  );

  modport slave (
    input  S_Data,
    input  S_Valid,
    output S_Ready
  );

endinterface

// File: rtl/conv_quan_param_loader.sv
// Streams bias/scale/shift words per output-channel group into the
// quantization parameter RAMs and pulses Load_Done when finished.
module conv_quan_param_loader #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_DATA_ADD        = 32,
  parameter int WIDTH_SHIFT           = 8,
  parameter int WIDTH_BIAS_RAM_ADDRA  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic Start_Load,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
  conv_quan_param_loader_if.slave s,
  output logic bias_wea,
  output logic scale_wea,
  output logic shift_wea,
  output logic [WIDTH_BIAS_RAM_ADDRA-1:0] param_addra,
  output logic [CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] bias_dina,
  output logic [CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] scale_dina,
  output logic [CHANNEL_OUT_NUM*WIDTH_SHIFT-1:0] shift_dina,
  output logic Busy,
  output logic Load_Done
);

  import conv_quan_param_loader_pkg::*;

  localparam int CW = WIDTH_CHANNEL_NUM_REG;
  localparam int SW = CHANNEL_OUT_NUM*WIDTH_SHIFT;

  state_t state, nxt;

  logic [CW-1:0] grp_cnt;
  logic [CW-1:0] grp_num;
  logic [CW-1:0] grp_req;
  logic          start;
  logic          acc;
  logic          last;

  assign grp_req   = Channel_Out_Num_REG >> GROUP_SHIFT;
  assign start     = (state == ST_IDLE) && Start_Load;
  assign s.S_Ready = (state == ST_LD_BIAS)
                  || (state == ST_LD_SCALE)
                  || (state == ST_LD_SHIFT);
  assign acc       = s.S_Valid && s.S_Ready;
  assign last      = (grp_cnt + CW'(1)) == grp_num;
  assign Busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (Start_Load)
          nxt = (grp_req == '0) ? ST_DONE : ST_LD_BIAS;
      end
      ST_LD_BIAS:  if (acc) nxt = ST_LD_SCALE;
      ST_LD_SCALE: if (acc) nxt = ST_LD_SHIFT;
      ST_LD_SHIFT: if (acc) nxt = last ? ST_DONE : ST_LD_BIAS;
      ST_DONE:     nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  // One-cycle registered write port; address is the group at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt     <= '0;
      grp_num     <= '0;
      bias_wea    <= 1'b0;
      scale_wea   <= 1'b0;
      shift_wea   <= 1'b0;
      param_addra <= '0;
      bias_dina   <= '0;
      scale_dina  <= '0;
      shift_dina  <= '0;
      Load_Done   <= 1'b0;
    end else begin
      Load_Done <= (nxt == ST_DONE);
      bias_wea  <= acc && (state == ST_LD_BIAS);
      scale_wea <= acc && (state == ST_LD_SCALE);
      shift_wea <= acc && (state == ST_LD_SHIFT);
      if (acc)
        param_addra <= grp_cnt[WIDTH_BIAS_RAM_ADDRA-1:0];
      if (acc && (state == ST_LD_BIAS))
        bias_dina <= s.S_Data;
      if (acc && (state == ST_LD_SCALE))
        scale_dina <= s.S_Data;
      if (acc && (state == ST_LD_SHIFT))
        shift_dina <= s.S_Data[SW-1:0];
      if (start) begin
        grp_cnt <= '0;
        grp_num <= grp_req;
      end else if (acc && (state == ST_LD_SHIFT)) begin
        grp_cnt <= grp_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_quan_param_loader.sv
// Bench for the quantization parameter loader: table of load runs,
// write scoreboard, plus reset-mid-load sequence.
module tb_conv_quan_param_loader;

  localparam int DW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start_Load = 1'b0;
  logic [9:0]  Channel_Out_Num_REG = '0;
  logic        bias_wea, scale_wea, shift_wea;
  logic [8:0]  param_addra;
  logic [DW-1:0] bias_dina, scale_dina;
  logic [63:0] shift_dina;
  logic        Busy, Load_Done;

  conv_quan_param_loader_if #(.DATA_W(DW)) sif ();

  conv_quan_param_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .Start_Load          (Start_Load),
    .Channel_Out_Num_REG (Channel_Out_Num_REG),
    .s                   (sif),
    .bias_wea            (bias_wea),
    .scale_wea           (scale_wea),
    .shift_wea           (shift_wea),
    .param_addra         (param_addra),
    .bias_dina           (bias_dina),
    .scale_dina          (scale_dina),
    .shift_dina          (shift_dina),
    .Busy                (Busy),
    .Load_Done           (Load_Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [8:0]  addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int chan;
    bit gap;
    bit disturb;
    int exp_busy;
  } vec_t;

  wr_t  q[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  nw;
    int  k;
    if (Busy) busy_cnt++;
    if (Load_Done) done_cnt++;
    nw = int'(bias_wea) + int'(scale_wea) + int'(shift_wea);
    if (nw > 1) begin
      chk("one_we", DW'(nw), DW'(1));
    end else if (nw == 1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", DW'(1), DW'(0));
      end else begin
        e = q.pop_front();
        k = bias_wea ? 0 : (scale_wea ? 1 : 2);
        chk("wr_kind", DW'(k), DW'(e.kind));
        chk("wr_addr", DW'(param_addra), DW'(e.addr));
        if (k == 0)      chk("bias_dina", bias_dina, e.data);
        else if (k == 1) chk("scale_dina", scale_dina, e.data);
        else             chk("shift_dina", DW'(shift_dina), e.data);
      end
    end
  end

  task automatic drive_beat(input int b);
    logic [DW-1:0] d;
    wr_t e;
    bit ok;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    sif.S_Data  = d;
    sif.S_Valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (sif.S_Ready) ok = 1'b1;
      else @(posedge clk);
    end
    if (!ok) begin
      chk("ready_timeout", DW'(0), DW'(1));
    end else begin
      e.kind = b % 3;
      e.addr = 9'(b / 3);
      e.data = (e.kind == 2) ? DW'(d[63:0]) : d;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input vec_t v);
    int g;
    int b0;
    int d0;
    g  = v.chan >> 3;
    @(posedge clk); #1;
    b0 = busy_cnt;
    d0 = done_cnt;
    Channel_Out_Num_REG = 10'(v.chan);
    Start_Load = 1'b1;
    @(posedge clk); #1;
    Start_Load = 1'b0;
    for (int b = 0; b < 3*g; b++) begin
      drive_beat(b);
      if (v.disturb && b == 1) begin
        Start_Load = 1'b1;
        Channel_Out_Num_REG = 10'd64;
      end
      if (v.disturb && b == 4) Start_Load = 1'b0;
      if (v.gap && b != 3*g-1) begin
        sif.S_Valid = 1'b0;
        @(negedge clk);
        chk("ready_in_gap", DW'(sif.S_Ready), DW'(1));
        @(posedge clk); #1;
      end
    end
    sif.S_Valid = 1'b0;
    if (v.disturb) Start_Load = 1'b1;
    @(negedge clk);
    chk("done_pulse", DW'(Load_Done), DW'(1));
    chk("busy_in_done", DW'(Busy), DW'(1));
    chk("ready_in_done", DW'(sif.S_Ready), DW'(0));
    @(posedge clk); #1;
    Start_Load = 1'b0;
    @(negedge clk); #1;
    chk("done_low", DW'(Load_Done), DW'(0));
    chk("busy_low", DW'(Busy), DW'(0));
    chk("busy_cycles", DW'(busy_cnt - b0), DW'(v.exp_busy));
    chk("done_count", DW'(done_cnt - d0), DW'(1));
    chk("sb_empty", DW'(q.size()), DW'(0));
  endtask

  initial begin
    vt[0] = '{16,   1'b0, 1'b0, 7};
    vt[1] = '{8,    1'b1, 1'b0, 6};
    vt[2] = '{4,    1'b0, 1'b0, 1};
    vt[3] = '{16,   1'b0, 1'b1, 7};
    vt[4] = '{24,   1'b1, 1'b0, 18};
    vt[5] = '{1016, 1'b0, 1'b0, 382};
    sif.S_Valid = 1'b0;
    sif.S_Data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", DW'(sif.S_Ready), DW'(0));
    chk("rst_busy", DW'(Busy), DW'(0));
    chk("rst_done", DW'(Load_Done), DW'(0));
    chk("rst_we", DW'({bias_wea, scale_wea, shift_wea}), DW'(0));
    chk("rst_addr", DW'(param_addra), DW'(0));
    chk("rst_bias", bias_dina, DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) run_load(vt[i]);

    // Reset after the group-1 bias beat, then a fresh load from address 0.
    @(posedge clk); #1;
    Channel_Out_Num_REG = 10'd16;
    Start_Load = 1'b1;
    @(posedge clk); #1;
    Start_Load = 1'b0;
    for (int b = 0; b < 4; b++) drive_beat(b);
    sif.S_Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_we", DW'({bias_wea, scale_wea, shift_wea}), DW'(0));
    chk("mid_rst_busy", DW'(Busy), DW'(0));
    chk("mid_rst_ready", DW'(sif.S_Ready), DW'(0));
    chk("mid_rst_sb", DW'(q.size()), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_load(vt[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_quan_param_loader.md
Name: conv_quan_param_loader

Overview:
- Loads per-output-channel quantization parameters (bias, scale, shift) from a stream into the bias/scale/shift RAMs read by the conv quantization controller.
- Sits between the DMA/stream front end and the quantization stage.
- Run once per layer. Its Load_Done pulse releases the quantization controller's Start.

Parameters:
- CHANNEL_OUT_NUM, 8, output channels per parameter group (per RAM word)
- WIDTH_CHANNEL_NUM_REG, 10, width of the output-channel-count register
- WIDTH_DATA_ADD, 32, width of one bias or scale value
- WIDTH_SHIFT, 8, width of one shift value
- WIDTH_BIAS_RAM_ADDRA, 9, RAM address width (group index)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Start_Load  in  1  begin a load; sampled only in IDLE
- Channel_Out_Num_REG  in  WIDTH_CHANNEL_NUM_REG  output channel count; groups = value>>3
- S_Data  in  CHANNEL_OUT_NUM*WIDTH_DATA_ADD  parameter beat
- S_Valid  in  1  beat valid
- S_Ready  out  1  loader accepts beat
- bias_wea  out  1  bias RAM write enable
- scale_wea  out  1  scale RAM write enable
- shift_wea  out  1  shift RAM write enable
- param_addra  out  WIDTH_BIAS_RAM_ADDRA  shared write address (group index)
- bias_dina  out  CHANNEL_OUT_NUM*WIDTH_DATA_ADD  bias word
- scale_dina  out  CHANNEL_OUT_NUM*WIDTH_DATA_ADD  scale word
- shift_dina  out  CHANNEL_OUT_NUM*WIDTH_SHIFT  shift word (S_Data low bits)
- Busy  out  1  high from load accept until Load_Done
- Load_Done  out  1  one-cycle pulse when all groups are written

Behaviour:
- Reset values:
  - State is IDLE.
  - All write enables, S_Ready, Busy and Load_Done are 0.
  - param_addra, data outputs and the group counter are 0.
- Reset mid-load: return to IDLE next cycle and drop the enables. RAM contents written so far are not cleared.
- States and transitions:
  - IDLE -> LD_BIAS on Start_Load.
  - LD_BIAS -> LD_SCALE on an accepted beat.
  - LD_SCALE -> LD_SHIFT on an accepted beat.
  - LD_SHIFT -> LD_BIAS on an accepted beat if the group is not last, else -> DONE.
  - DONE -> IDLE unconditionally.
- Zero-group case: Start_Load with Channel_Out_Num_REG>>3 == 0 goes IDLE -> DONE directly. Load_Done pulses and no writes occur.
- Channel count latch: Channel_Out_Num_REG>>3 is latched on Start_Load acceptance. Register changes during a load are ignored.
- S_Ready is combinational: 1 exactly in LD_BIAS, LD_SCALE and LD_SHIFT. A beat is accepted when S_Valid && S_Ready. S_Valid low stalls the loader in its current state indefinitely.
- Write latency is 1 cycle. The cycle after a beat is accepted in LD_x:
  - x_wea = 1 for exactly one cycle;
  - param_addra = group counter at acceptance;
  - x_dina = registered S_Data (truncated to width for shift).
- Only one write enable is high in any cycle.
- Group counter:
  - clears on Start_Load;
  - increments on an accepted LD_SHIFT beat;
  - last group when counter+1 == latched groups.
- Address width: the counter is WIDTH_CHANNEL_NUM_REG wide; param_addra is its low WIDTH_BIAS_RAM_ADDRA bits.
- Busy is 1 in LD_* and DONE states and 0 in IDLE.
- Load_Done is registered:
  - it is high the cycle the state is DONE;
  - the final shift_wea is asserted in that same cycle.
- Start_Load while not in IDLE is ignored. Start_Load in the DONE cycle is also ignored.

Decomposition:
- Shared package holds:
  - state encodings (one-hot, 5 bits: IDLE, LD_BIAS, LD_SCALE, LD_SHIFT, DONE);
  - CHANNEL_OUT_NUM;
  - the group shift constant 3.
- Single module; no sub-module needed.
- The write-port register stage may be a small generic "stream_to_ram_wr" helper if reused by the weight loader.

Test Plan:
- Channel_Out_Num_REG=16, S_Valid always 1, distinct beats B0..B5 -> writes:
  - bias@0=B0, scale@0=B1, shift@0=B2[63:0];
  - bias@1=B3, scale@1=B4, shift@1=B5[63:0];
  - one enable per cycle; Load_Done 1 cycle after final accept; Busy high 7 cycles.
- Channel_Out_Num_REG=8 with S_Valid toggling 1/0 every cycle -> 3 writes at address 0. S_Ready stays 1 in LD_* and state holds during gaps. Load_Done fires once.
- Channel_Out_Num_REG=4 (groups=0) -> Load_Done the cycle after Start_Load, S_Ready never high, no enables.
- Start_Load re-pulsed mid-load and Channel_Out_Num_REG changed to 64 mid-load -> ignored; the original group count completes.
- rst asserted after bias beat of group 1 -> next cycle IDLE, all enables 0, Busy 0. A new Start_Load loads from address 0.
- Channel_Out_Num_REG=1016 (127 groups) -> last writes at param_addra=126. Load_Done after 381 accepted beats.
